// File: rtl/reference_model_pkg.sv
// Shared definitions for the DMA register-access reference decoder:
// slave-bus register addresses, controller state encodings and decode records.
package reference_model_pkg;

  localparam logic [3:0] ADDR_CMD_STATUS = 4'b1000;
  localparam logic [3:0] ADDR_REQ        = 4'b1001;
  localparam logic [3:0] ADDR_SMASK      = 4'b1010;
  localparam logic [3:0] ADDR_MODE       = 4'b1011;
  localparam logic [3:0] ADDR_CLRFF      = 4'b1100;
  localparam logic [3:0] ADDR_MCLR       = 4'b1101;
  localparam logic [3:0] ADDR_CLRMASK    = 4'b1110;
  localparam logic [3:0] ADDR_AMASK      = 4'b1111;

  typedef enum logic [5:0] {
    SI = 6'b000001,
    SO = 6'b000010,
    S1 = 6'b000100,
    S2 = 6'b001000,
    S3 = 6'b010000,
    S4 = 6'b100000
  } dmaState_t;

  typedef struct packed {
    logic baseAddress;
    logic baseWordCount;
    logic command;
    logic request;
    logic singleMask;
    logic mode;
    logic clearFF;
    logic masterClear;
    logic clearMask;
    logic allMask;
  } wrSel_t;

  typedef struct packed {
    logic currentAddress;
    logic currentWordCount;
    logic status;
  } rdSel_t;

  // Low half of the map holds the per-channel address/word-count pairs.
  function automatic logic isChannelReg(input logic [3:0] addr);
    return ~addr[3];
  endfunction

endpackage

// File: rtl/reference_model_reg_addr_decode.sv
// Combinational address-nibble decoder producing one-hot read and write
// register selects for the 8237-style register map.
module reg_addr_decode
  import reference_model_pkg::*;
(
  input  logic [3:0] addr,
  output wrSel_t     wrSel,
  output rdSel_t     rdSel
);

  always_comb begin
    wrSel = '0;
    rdSel = '0;
    if (isChannelReg(addr)) begin
      wrSel.baseAddress      = ~addr[0];
      wrSel.baseWordCount    = addr[0];
      rdSel.currentAddress   = ~addr[0];
      rdSel.currentWordCount = addr[0];
    end else begin
      unique case (addr)
        ADDR_CMD_STATUS: begin
          wrSel.command = 1'b1;
          rdSel.status  = 1'b1;
        end
        ADDR_REQ:     wrSel.request    = 1'b1;
        ADDR_SMASK:   wrSel.singleMask = 1'b1;
        ADDR_MODE:    wrSel.mode       = 1'b1;
        ADDR_CLRFF:   wrSel.clearFF    = 1'b1;
        // Master clear also resets the byte pointer.
        ADDR_MCLR: begin
          wrSel.masterClear = 1'b1;
          wrSel.clearFF     = 1'b1;
        end
        ADDR_CLRMASK: wrSel.clearMask  = 1'b1;
        ADDR_AMASK:   wrSel.allMask    = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/reference_model.sv
// Cycle-accurate reference for the DMA controller's CPU register access path:
// access-start detection, registered write strobes and the byte-pointer flip-flop.
module reference_model
  import reference_model_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CS_N,
  input  logic       IOR_N,
  input  logic       IOW_N,
  input  logic       A3,
  input  logic       A2,
  input  logic       A1,
  input  logic       A0,
  input  logic       programCondition,
  output logic       loadIoDataBufferFromDB,
  output logic       loadIoDataBufferFromStatus,
  output logic       readStatusReg,
  output logic       readCurrentAddressReg,
  output logic       readCurrentWordCountReg,
  output logic       loadBaseAddressReg,
  output logic       loadBaseWordCountReg,
  output logic       loadCommandReg,
  output logic       loadModeReg,
  output logic       loadRequestReg,
  output logic       loadSingleMask,
  output logic       loadAllMask,
  output logic       clearMaskReg,
  output logic       masterClear,
  output logic       clearInternalFF,
  output logic [1:0] channelSel,
  output logic       internalFF
);

  logic [3:0] addr;
  logic       wr;
  logic       rd;
  logic       wrPrev;
  logic       rdPrev;
  logic       wrStart;
  logic       rdStart;
  logic       togglePending;
  logic       ffQ;
  logic [1:0] chanQ;
  wrSel_t     wrDec;
  wrSel_t     wrStrobe;
  rdSel_t     rdDec;

  assign addr    = {A3, A2, A1, A0};
  assign wr      = programCondition & ~CS_N & ~IOW_N &  IOR_N;
  assign rd      = programCondition & ~CS_N & ~IOR_N &  IOW_N;
  assign wrStart = wr & ~wrPrev;
  assign rdStart = rd & ~rdPrev;

  reg_addr_decode uDecode (
    .addr  (addr),
    .wrSel (wrDec),
    .rdSel (rdDec)
  );

  // Toggle is deferred one cycle so the flip-flop moves on the edge ending T+1,
  // the same edge as the clear strobe; clear therefore wins when both coincide.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrPrev        <= 1'b0;
      rdPrev        <= 1'b0;
      wrStrobe      <= '0;
      togglePending <= 1'b0;
      chanQ         <= '0;
      ffQ           <= 1'b0;
    end else begin
      wrPrev        <= wr;
      rdPrev        <= rd;
      wrStrobe      <= wrStart ? wrDec : '0;
      togglePending <= (wrStart | rdStart) & isChannelReg(addr);
      if (wrStart | rdStart) begin
        chanQ <= {A2, A1};
      end
      if (wrStrobe.clearFF | wrStrobe.masterClear) begin
        ffQ <= 1'b0;
      end else if (togglePending) begin
        ffQ <= ~ffQ;
      end
    end
  end

  assign loadIoDataBufferFromDB     = wr;
  assign readStatusReg              = rd & rdDec.status;
  assign loadIoDataBufferFromStatus = rd & rdDec.status;
  assign readCurrentAddressReg      = rd & rdDec.currentAddress;
  assign readCurrentWordCountReg    = rd & rdDec.currentWordCount;

  assign loadBaseAddressReg   = wrStrobe.baseAddress;
  assign loadBaseWordCountReg = wrStrobe.baseWordCount;
  assign loadCommandReg       = wrStrobe.command;
  assign loadModeReg          = wrStrobe.mode;
  assign loadRequestReg       = wrStrobe.request;
  assign loadSingleMask       = wrStrobe.singleMask;
  assign loadAllMask          = wrStrobe.allMask;
  assign clearMaskReg         = wrStrobe.clearMask;
  assign masterClear          = wrStrobe.masterClear;
  assign clearInternalFF      = wrStrobe.clearFF;

  assign channelSel = chanQ;
  assign internalFF = ffQ;

endmodule

// File: tb/tb_reference_model.sv
// Scoreboard bench for reference_model: directed plan sequences followed by
// random bus traffic, checked every cycle against a behavioural model.
module tb_reference_model;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CS_N = 1'b1;
  logic       IOR_N = 1'b1;
  logic       IOW_N = 1'b1;
  logic       A3 = 1'b0, A2 = 1'b0, A1 = 1'b0, A0 = 1'b0;
  logic       programCondition = 1'b0;
  logic       loadIoDataBufferFromDB, loadIoDataBufferFromStatus;
  logic       readStatusReg, readCurrentAddressReg, readCurrentWordCountReg;
  logic       loadBaseAddressReg, loadBaseWordCountReg, loadCommandReg, loadModeReg;
  logic       loadRequestReg, loadSingleMask, loadAllMask, clearMaskReg;
  logic       masterClear, clearInternalFF;
  logic [1:0] channelSel;
  logic       internalFF;

  reference_model dut (
    .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .A3(A3), .A2(A2), .A1(A1), .A0(A0), .programCondition(programCondition),
    .loadIoDataBufferFromDB(loadIoDataBufferFromDB),
    .loadIoDataBufferFromStatus(loadIoDataBufferFromStatus),
    .readStatusReg(readStatusReg), .readCurrentAddressReg(readCurrentAddressReg),
    .readCurrentWordCountReg(readCurrentWordCountReg),
    .loadBaseAddressReg(loadBaseAddressReg), .loadBaseWordCountReg(loadBaseWordCountReg),
    .loadCommandReg(loadCommandReg), .loadModeReg(loadModeReg),
    .loadRequestReg(loadRequestReg), .loadSingleMask(loadSingleMask),
    .loadAllMask(loadAllMask), .clearMaskReg(clearMaskReg),
    .masterClear(masterClear), .clearInternalFF(clearInternalFF),
    .channelSel(channelSel), .internalFF(internalFF)
  );

  always #5 CLK = ~CLK;

  // Observed vector order:
  // {dbLoad, statusLoad, rdStatus, rdCurAddr, rdCurWc, baseAddr, baseWc, cmd,
  //  mode, req, sMask, aMask, clrMask, mclr, clrFF, channelSel[1:0], internalFF}
  typedef logic [17:0] obs_t;

  obs_t        expQ[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  // Behavioural model state
  bit          mPrevWr, mPrevRd;
  bit          mWriteDue;
  logic [3:0]  mWriteAddr;
  bit          mToggleDue;
  int unsigned mAccessCount;
  logic [1:0]  mChan;

  // Write strobe pattern named by a register address:
  // {baseAddr, baseWc, cmd, mode, req, sMask, aMask, clrMask, mclr, clrFF}
  function automatic logic [9:0] writeEffect(input logic [3:0] a);
    if (!a[3]) return a[0] ? 10'b0100000000 : 10'b1000000000;
    case (a[2:0])
      3'd0: return 10'b0010000000;
      3'd1: return 10'b0000100000;
      3'd2: return 10'b0000010000;
      3'd3: return 10'b0001000000;
      3'd4: return 10'b0000000001;
      3'd5: return 10'b0000000011;
      3'd6: return 10'b0000000100;
      default: return 10'b0000001000;
    endcase
  endfunction

  function automatic obs_t sampleDut();
    return {loadIoDataBufferFromDB, loadIoDataBufferFromStatus, readStatusReg,
            readCurrentAddressReg, readCurrentWordCountReg, loadBaseAddressReg,
            loadBaseWordCountReg, loadCommandReg, loadModeReg, loadRequestReg,
            loadSingleMask, loadAllMask, clearMaskReg, masterClear, clearInternalFF,
            channelSel, internalFF};
  endfunction

  // Drive one cycle's inputs, predict the cycle's outputs, then advance the model
  // across the closing clock edge.
  task automatic cyc(input bit rst, input bit cs, input bit ior, input bit iow,
                     input logic [3:0] a, input bit pc);
    bit         wrQ, rdQ, accessStart;
    logic [2:0] rdBits;
    logic [9:0] wrBits;
    RESET = rst; CS_N = cs; IOR_N = ior; IOW_N = iow; programCondition = pc;
    {A3, A2, A1, A0} = a;
    wrQ = pc && !cs && !iow && ior;
    rdQ = pc && !cs && !ior && iow;
    rdBits = '0;
    if (rdQ) begin
      if (a == 4'b1000)  rdBits = 3'b100;
      else if (!a[3])    rdBits = a[0] ? 3'b001 : 3'b010;
    end
    wrBits = mWriteDue ? writeEffect(mWriteAddr) : '0;
    expQ.push_back({wrQ, rdBits[2], rdBits[2], rdBits[1], rdBits[0], wrBits,
                    mChan, mAccessCount[0]});
    if (rst) begin
      mPrevWr = 0; mPrevRd = 0; mWriteDue = 0; mWriteAddr = '0;
      mToggleDue = 0; mAccessCount = 0; mChan = '0;
    end else begin
      if (wrBits[0]) mAccessCount = 0;
      else if (mToggleDue) mAccessCount++;
      accessStart = (wrQ && !mPrevWr) || (rdQ && !mPrevRd);
      mToggleDue = accessStart && !a[3];
      if (accessStart) mChan = a[2:1];
      mWriteDue = wrQ && !mPrevWr;
      mWriteAddr = a;
      mPrevWr = wrQ; mPrevRd = rdQ;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 1, 1, 1, 4'b0000, 1);
  endtask

  task automatic wrAcc(input logic [3:0] a, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 1, 0, a, 1);
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the queued prediction
  initial begin
    obs_t got, exp;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        got = sampleDut();
        checks++;
        if (got !== exp)
          $display("FAIL outputs check#%0d t=%0t got=%b exp=%b", checks, $time, got, exp);
        else
          passes++;
      end
    end
  end

  initial begin
    int unsigned budget;
    // Reset edge before any prediction is recorded
    @(posedge CLK);
    #1;
    cyc(1, 1, 1, 1, 4'b0000, 1);
    idle(2);
    wrAcc(4'b1000, 3);                      // command write held 3 cycles
    idle(2);
    wrAcc(4'b0000, 1); idle(1); wrAcc(4'b0000, 1); idle(3);
    wrAcc(4'b0010, 1); idle(1); wrAcc(4'b1100, 1); idle(1); wrAcc(4'b0011, 1); idle(3);
    cyc(0, 0, 0, 1, 4'b1000, 1); cyc(0, 0, 0, 1, 4'b1000, 1); idle(1);   // status read
    cyc(0, 0, 0, 1, 4'b0001, 1); idle(1);                                 // channel read toggles FF
    cyc(0, 0, 0, 0, 4'b0000, 1); cyc(0, 0, 0, 0, 4'b1000, 1); idle(2);   // both strobes low
    cyc(0, 0, 1, 0, 4'b1011, 0); cyc(0, 0, 1, 0, 4'b1011, 0); idle(2);   // not in program condition
    cyc(0, 0, 1, 0, 4'b1011, 1); cyc(0, 0, 1, 0, 4'b1011, 0); idle(2);   // condition drops mid-access
    wrAcc(4'b0100, 1); idle(1);
    wrAcc(4'b1101, 1); idle(3);                                          // master clear
    wrAcc(4'b0110, 2); cyc(1, 0, 1, 0, 4'b0110, 1); wrAcc(4'b0110, 2); idle(3); // reset mid-strobe
    for (int unsigned i = 0; i < 500; i++) begin
      bit         rst, cs, ior, iow, pc;
      logic [3:0] a;
      int unsigned hold;
      rst  = ($urandom_range(0, 40) == 0);
      cs   = ($urandom_range(0, 5) == 0);
      ior  = ($urandom_range(0, 2) != 0);
      iow  = ($urandom_range(0, 2) != 0);
      pc   = ($urandom_range(0, 7) != 0);
      a    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 3);
      for (int unsigned h = 0; h < hold; h++) cyc(rst && (h == 0), cs, ior, iow, a, pc);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
    budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    if (expQ.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reference_model.md
# reference_model

Cycle-accurate reference decoder for the DMA controller's CPU-side register access path (8237-style register map). It watches the slave bus (chip select, I/O strobes, low address nibble) while the controller is in program condition, and produces the expected internal load/read strobes plus the expected byte-pointer flip-flop value. It sits beside the DMA controller inside the checker, and assertions compare its outputs against the controller's internal registers.

## Interface
- Parameters: none.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high.
- `CS_N` input 1: chip select, active low.
- `IOR_N` input 1: I/O read strobe, active low.
- `IOW_N` input 1: I/O write strobe, active low.
- `A3`, `A2`, `A1`, `A0` input 1 each: register address nibble.
- `programCondition` input 1: controller is idle and programmable.
- `loadIoDataBufferFromDB` output 1: the I/O data buffer captures the data bus (DB) this cycle.
- `loadIoDataBufferFromStatus` output 1: the I/O data buffer captures the status register this cycle.
- `readStatusReg`, `readCurrentAddressReg`, `readCurrentWordCountReg` output 1 each: read-access decodes.
- `loadBaseAddressReg`, `loadBaseWordCountReg` output 1 each: load the base register and the matching current register.
- `loadCommandReg`, `loadModeReg`, `loadRequestReg`, `loadSingleMask`, `loadAllMask`, `clearMaskReg`, `masterClear`, `clearInternalFF` output 1 each: write-access strobes.
- `channelSel` output 2: channel addressed by the strobe (`A2:A1`).
- `internalFF` output 1: expected byte-pointer flip-flop (0 = low byte next).

## Operation
- Write qualifier `wr = programCondition & !CS_N & !IOW_N & IOR_N`.
- Read qualifier `rd = programCondition & !CS_N & !IOR_N & IOW_N`.
- If IOR_N and IOW_N are both low, neither qualifier is true and no strobe fires.
- `loadIoDataBufferFromDB = wr` (combinational, level).
- Read decode (combinational, level, while `rd`):
  - `A3=0, A0=0` → readCurrentAddressReg
  - `A3=0, A0=1` → readCurrentWordCountReg
  - `1000` → readStatusReg and loadIoDataBufferFromStatus
- Write decode, based on the address of the first `wr` cycle:
  - `A3=0, A0=0` → loadBaseAddressReg
  - `A3=0, A0=1` → loadBaseWordCountReg
  - `1000` → loadCommandReg
  - `1001` → loadRequestReg
  - `1010` → loadSingleMask
  - `1011` → loadModeReg
  - `1100` → clearInternalFF
  - `1101` → masterClear and clearInternalFF
  - `1110` → clearMaskReg
  - `1111` → loadAllMask
- Access start is the rising edge of `wr` or `rd` (qualifier low in the previous cycle). A held strobe counts as one access.
- `internalFF` behaviour:
  - Toggles once per access start to any `A3=0` register, read or write.
  - Cleared by clearInternalFF, masterClear or RESET. Clear wins over a simultaneous toggle.
- `channelSel` = registered `A2:A1` of the access start; it is held until the next access.

## Timing
- Read decodes and loadIoDataBufferFromDB are combinational in the access cycle T.
- Write strobes (load*/clear*/masterClear) are registered. They are high for exactly cycle T+1 after access start T, so they align with the I/O data buffer holding the captured DB.
- `internalFF` updates at the edge ending T+1, the same edge at which the controller's own flip-flop updates.
- Reset:
  - RESET high at an edge → all registered outputs 0 and `internalFF`=0 at the next cycle.
  - Any pending strobe is discarded.
  - Edge detection restarts, so a strobe still held low after reset counts as a new access.
- programCondition falling mid-access ends the access. A strobe already registered still fires in T+1.
- Back-to-back accesses need at least one inactive cycle between them.

## Structure
- Shared package: the 4-bit register address constants (`ADDR_CMD_STATUS=4'b1000`, `ADDR_REQ`, `ADDR_SMASK`, `ADDR_MODE`, `ADDR_CLRFF`, `ADDR_MCLR`, `ADDR_CLRMASK`, `ADDR_AMASK`) and the controller state encodings (SI, SO, S1, S2, S3, S4; one-hot, 6 bits).
- Optional sub-module `reg_addr_decode`: purely combinational, address nibble → one-hot register select.
- Top level holds the edge detect, strobe pipeline and flip-flop.

## Test plan
- RESET 1 cycle → all outputs 0, `internalFF`=0.
- CS_N=0, IOW_N=0 for 3 cycles, addr=1000, programCondition=1 →
  - loadIoDataBufferFromDB high 3 cycles
  - loadCommandReg high exactly one cycle, one cycle after the first write cycle
- Write addr 0000, then write 0000 again → loadBaseAddressReg twice, `channelSel`=0, `internalFF` goes 0→1→0.
- Write 0010, then write 1100 (clear FF), then write 0011 →
  - `internalFF` 1 after the first write, 0 after the clear, 1 after the third
  - `channelSel`=1 on the last access
- Read 1000 with IOR_N=0 → readStatusReg and loadIoDataBufferFromStatus high the same cycle, no write strobes; IOR_N=IOW_N=0 → no outputs.
- programCondition=0 during a write to 1011 → no loadModeReg. Write 1101 → masterClear and clearInternalFF high in T+1.
